// File: rtl/sw_gate_lab.sv
// Switch-driven N-input gate with debounced mode/clear keys, rising-edge counter
// and seven-segment readout of the count and current gate mode.
module sw_gate_lab #(
    parameter int N_IN       = 2,
    parameter int DEB_CYCLES = 50000,
    parameter int CNT_W      = 8
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic [N_IN-1:0]   SW,
    input  logic              KEY_MODE,
    input  logic              KEY_CLR,
    output logic [N_IN-1:0]   LED_IN,
    output logic              LED_OUT,
    output logic [1:0]        MODE,
    output logic [CNT_W-1:0]  EDGE_CNT,
    output logic [6:0]        HEX0,
    output logic [6:0]        HEX1,
    output logic [6:0]        HEX5
);

    localparam int NB = N_IN + 2;
    localparam int KM = N_IN;
    localparam int KC = N_IN + 1;
    localparam int PW = $clog2(DEB_CYCLES);
    localparam logic [PW-1:0] PRE_MAX = PW'(DEB_CYCLES - 1);
    // Keys idle high (released), switches idle low.
    localparam logic [NB-1:0] RST_VAL = {2'b11, {N_IN{1'b0}}};

    typedef enum logic [1:0] {
        M_AND  = 2'd0,
        M_OR   = 2'd1,
        M_XOR  = 2'd2,
        M_NAND = 2'd3
    } mode_t;

    logic [NB-1:0]    raw;
    logic [NB-1:0]    sync1_q, sync1_d, sync2_q, sync2_d;
    logic [NB-1:0]    smp_q, smp_d, deb_q, deb_d;
    logic [1:0]       key_prev_q, key_prev_d;
    logic [PW-1:0]    pre_q, pre_d;
    mode_t            mode_q, mode_d;
    logic             led_out_q, led_out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick, mode_press, clr_press, rise;
    logic [7:0]       cnt_byte;

    assign raw = {KEY_CLR, KEY_MODE, SW};

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            sync1_q    <= RST_VAL;
            sync2_q    <= RST_VAL;
            smp_q      <= RST_VAL;
            deb_q      <= RST_VAL;
            key_prev_q <= 2'b11;
            pre_q      <= '0;
            mode_q     <= M_AND;
            led_out_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            smp_q      <= smp_d;
            deb_q      <= deb_d;
            key_prev_q <= key_prev_d;
            pre_q      <= pre_d;
            mode_q     <= mode_d;
            led_out_q  <= led_out_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        sync1_d    = raw;
        sync2_d    = sync1_q;
        tick       = (pre_q == PRE_MAX);
        pre_d      = tick ? '0 : pre_q + PW'(1);
        smp_d      = tick ? sync2_q : smp_q;
        deb_d      = deb_q;
        // A bit only moves when two consecutive tick samples agree.
        for (int i = 0; i < NB; i++) begin
            if (tick && (sync2_q[i] == smp_q[i])) begin
                deb_d[i] = sync2_q[i];
            end
        end
        key_prev_d = {deb_q[KC], deb_q[KM]};
        mode_press = key_prev_q[0] & ~deb_q[KM];
        clr_press  = key_prev_q[1] & ~deb_q[KC];

        mode_d = mode_q;
        if (mode_press) begin
            case (mode_q)
                M_AND:   mode_d = M_OR;
                M_OR:    mode_d = M_XOR;
                M_XOR:   mode_d = M_NAND;
                M_NAND:  mode_d = M_AND;
                default: mode_d = M_AND;
            endcase
        end

        led_out_d = 1'b0;
        case (mode_q)
            M_AND:   led_out_d = &deb_q[N_IN-1:0];
            M_OR:    led_out_d = |deb_q[N_IN-1:0];
            M_XOR:   led_out_d = ^deb_q[N_IN-1:0];
            M_NAND:  led_out_d = ~&deb_q[N_IN-1:0];
            default: led_out_d = 1'b0;
        endcase

        // Clear has priority over a coincident rising edge.
        rise = led_out_d & ~led_out_q;
        if (clr_press) begin
            cnt_d = '0;
        end else if (rise) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        cnt_byte = '0;
        cnt_byte[CNT_W-1:0] = cnt_q;
    end

    assign LED_IN   = deb_q[N_IN-1:0];
    assign LED_OUT  = led_out_q;
    assign MODE     = mode_q;
    assign EDGE_CNT = cnt_q;
    assign HEX0     = seg7(cnt_byte[3:0]);
    assign HEX1     = seg7(cnt_byte[7:4]);
    assign HEX5     = seg7({2'b00, mode_q});

endmodule

// File: tb/tb_sw_gate_lab.sv
// Directed bench for sw_gate_lab with a short debounce period and 4 switches.
module tb_sw_gate_lab;

    logic       clk = 1'b0;
    logic       RESET;
    logic [3:0] SW;
    logic       KEY_MODE, KEY_CLR;
    logic [3:0] LED_IN;
    logic       LED_OUT;
    logic [1:0] MODE;
    logic [7:0] EDGE_CNT;
    logic [6:0] HEX0, HEX1, HEX5;

    int checks = 0;
    int errors = 0;

    sw_gate_lab #(.N_IN(4), .DEB_CYCLES(4), .CNT_W(8)) dut (
        .CLOCK_50 (clk),
        .RESET    (RESET),
        .SW       (SW),
        .KEY_MODE (KEY_MODE),
        .KEY_CLR  (KEY_CLR),
        .LED_IN   (LED_IN),
        .LED_OUT  (LED_OUT),
        .MODE     (MODE),
        .EDGE_CNT (EDGE_CNT),
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .HEX5     (HEX5)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_led(input logic val, input int budget, input string tag);
        int n = 0;
        while (LED_OUT !== val && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'b0, LED_OUT}, {31'b0, val});
    endtask

    task automatic press_mode();
        KEY_MODE = 1'b0;
        cyc(12);
        KEY_MODE = 1'b1;
        cyc(12);
    endtask

    task automatic press_clr();
        KEY_CLR = 1'b0;
        cyc(12);
        KEY_CLR = 1'b1;
        cyc(12);
    endtask

    task automatic chk_state(input string tag, input logic [1:0] m, input logic lo,
                             input logic [7:0] cnt);
        chk({tag, ".mode"}, {30'b0, MODE}, {30'b0, m});
        chk({tag, ".led_out"}, {31'b0, LED_OUT}, {31'b0, lo});
        chk({tag, ".cnt"}, {24'b0, EDGE_CNT}, {24'b0, cnt});
    endtask

    initial begin
        RESET    = 1'b1;
        SW       = 4'h0;
        KEY_MODE = 1'b1;
        KEY_CLR  = 1'b1;
        cyc(3);
        RESET = 1'b0;
        cyc(1);
        chk_state("rst", 2'd0, 1'b0, 8'h00);
        chk("rst.led_in", {28'b0, LED_IN}, 32'h0);
        chk("rst.hex0", {25'b0, HEX0}, 32'h40);
        chk("rst.hex1", {25'b0, HEX1}, 32'h40);
        chk("rst.hex5", {25'b0, HEX5}, 32'h40);

        SW = 4'hF;
        wait_led(1'b1, 11, "allon.rise");
        cyc(2);
        chk("allon.led_in", {28'b0, LED_IN}, 32'hF);
        chk("allon.cnt", {24'b0, EDGE_CNT}, 32'h1);
        chk("allon.hex0", {25'b0, HEX0}, 32'h79);

        SW = 4'hE;
        cyc(2);
        SW = 4'hF;
        cyc(16);
        chk("glitch.led_in", {28'b0, LED_IN}, 32'hF);
        chk_state("glitch", 2'd0, 1'b1, 8'h01);

        SW = 4'b0001;
        cyc(14);
        chk("sw1.led_in", {28'b0, LED_IN}, 32'h1);
        chk_state("sw1.and", 2'd0, 1'b0, 8'h01);
        press_mode();
        chk_state("m.or", 2'd1, 1'b1, 8'h02);
        chk("m.or.hex5", {25'b0, HEX5}, 32'h79);
        press_mode();
        chk_state("m.xor", 2'd2, 1'b1, 8'h02);
        chk("m.xor.hex5", {25'b0, HEX5}, 32'h24);
        press_mode();
        chk_state("m.nand", 2'd3, 1'b1, 8'h02);
        chk("m.nand.hex5", {25'b0, HEX5}, 32'h30);
        press_mode();
        chk_state("m.and", 2'd0, 1'b0, 8'h02);
        press_mode();
        chk_state("m.or2", 2'd1, 1'b1, 8'h03);
        chk("m.or2.hex0", {25'b0, HEX0}, 32'h30);

        press_clr();
        chk_state("clr", 2'd1, 1'b1, 8'h00);
        chk("clr.hex0", {25'b0, HEX0}, 32'h40);

        for (int i = 0; i < 256; i++) begin
            SW = 4'b0000;
            cyc(13);
            SW = 4'b0001;
            cyc(13);
            if (i == 254) begin
                chk("wrap.ff.cnt", {24'b0, EDGE_CNT}, 32'hFF);
                chk("wrap.ff.hex0", {25'b0, HEX0}, 32'h0E);
                chk("wrap.ff.hex1", {25'b0, HEX1}, 32'h0E);
            end
        end
        chk("wrap.00.cnt", {24'b0, EDGE_CNT}, 32'h00);
        chk("wrap.00.hex0", {25'b0, HEX0}, 32'h40);
        chk("wrap.00.hex1", {25'b0, HEX1}, 32'h40);

        SW = 4'b0000;
        cyc(13);
        SW = 4'b0001;
        cyc(13);
        SW = 4'b0000;
        cyc(13);
        chk_state("pre_coinc", 2'd1, 1'b0, 8'h01);
        SW      = 4'b0001;
        KEY_CLR = 1'b0;
        cyc(13);
        chk_state("coinc", 2'd1, 1'b1, 8'h00);
        KEY_CLR = 1'b1;
        cyc(13);

        SW = 4'b0000;
        cyc(13);
        SW = 4'b0001;
        cyc(13);
        chk_state("pre_rst", 2'd1, 1'b1, 8'h01);
        KEY_MODE = 1'b0;
        cyc(6);
        #2;
        RESET = 1'b1;
        #1;
        chk_state("async_rst", 2'd0, 1'b0, 8'h00);
        chk("async_rst.led_in", {28'b0, LED_IN}, 32'h0);
        chk("async_rst.hex5", {25'b0, HEX5}, 32'h40);
        chk("async_rst.hex0", {25'b0, HEX0}, 32'h40);
        KEY_MODE = 1'b1;
        cyc(2);
        RESET = 1'b0;
        cyc(30);
        chk_state("post_rst", 2'd0, 1'b0, 8'h00);
        chk("post_rst.led_in", {28'b0, LED_IN}, 32'h1);
        press_mode();
        chk_state("post_rst.press", 2'd1, 1'b1, 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
